// File: rtl/pump_sched_pkg.sv
// Shared types and default constants for the pump scheduler slice.
package pump_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RUN  = 2'd2
    } pump_state_t;

    localparam int unsigned NUM_PUMPS_D  = 4;
    localparam int unsigned MAX_ACTIVE_D = 2;
    localparam int unsigned DOSE_TICKS_D = 3;
    localparam int unsigned TICK_W_D     = 4;

    // Width of a pump index; a single-pump build still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pump_scheduler_if.sv
// Request/enable bundle between the switch front end and the pump scheduler.
interface pump_scheduler_if
    import pump_sched_pkg::*;
#(
    parameter int unsigned NUM_PUMPS = NUM_PUMPS_D
);
    logic                 tick;
    logic [NUM_PUMPS-1:0] req;
    logic                 abort;
    logic [NUM_PUMPS-1:0] pump;
    logic [NUM_PUMPS-1:0] done;
    logic [2:0]           active_cnt;
    logic                 busy;

    modport master (
        output tick, req, abort,
        input  pump, done, active_cnt, busy
    );

    modport slave (
        input  tick, req, abort,
        output pump, done, active_cnt, busy
    );
endinterface

// File: rtl/pump_slot.sv
// One pump channel: IDLE/PEND/RUN FSM, dose tick counter, registered pump/done.
module pump_slot
    import pump_sched_pkg::*;
#(
    parameter int unsigned DOSE_TICKS = DOSE_TICKS_D,
    parameter int unsigned TICK_W     = TICK_W_D
) (
    input  logic clk,
    input  logic RESET,
    input  logic grant,
    input  logic req,
    input  logic tick,
    input  logic abort,
    output logic pump,
    output logic done,
    output logic pend,
    output logic busy
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(DOSE_TICKS - 1);

    pump_state_t       state;
    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            pump  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            // An aborted dose never reports completion.
            state <= IDLE;
            cnt   <= '0;
            pump  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) state <= PEND;
                end
                PEND: begin
                    if (grant) begin
                        state <= RUN;
                        cnt   <= '0;
                        pump  <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (cnt == LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            pump  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + TICK_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pend = (state == PEND);
    assign busy = (state != IDLE);

endmodule

// File: rtl/pump_scheduler.sv
// Round-robin pump scheduler limiting the number of simultaneously running pumps.
module pump_scheduler
    import pump_sched_pkg::*;
#(
    parameter int unsigned NUM_PUMPS  = NUM_PUMPS_D,
    parameter int unsigned MAX_ACTIVE = MAX_ACTIVE_D,
    parameter int unsigned DOSE_TICKS = DOSE_TICKS_D,
    parameter int unsigned TICK_W     = TICK_W_D
) (
    input  logic             clk,
    input  logic             RESET,
    pump_scheduler_if.slave  bus
);

    localparam int unsigned PTR_W = ptr_width(NUM_PUMPS);

    logic [NUM_PUMPS-1:0] grant;
    logic [NUM_PUMPS-1:0] pend;
    logic [NUM_PUMPS-1:0] slot_busy;
    logic [NUM_PUMPS-1:0] pump_q;
    logic [NUM_PUMPS-1:0] done_q;
    logic [2:0]           active_cnt;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_next;
    logic                 found;
    int unsigned          sel;
    int unsigned          idx;

    for (genvar i = 0; i < NUM_PUMPS; i++) begin : g_slot
        pump_slot #(
            .DOSE_TICKS (DOSE_TICKS),
            .TICK_W     (TICK_W)
        ) u_slot (
            .clk   (clk),
            .RESET (RESET),
            .grant (grant[i]),
            .req   (bus.req[i]),
            .tick  (bus.tick),
            .abort (bus.abort),
            .pump  (pump_q[i]),
            .done  (done_q[i]),
            .pend  (pend[i]),
            .busy  (slot_busy[i])
        );
    end

    always_comb begin
        active_cnt = '0;
        for (int unsigned j = 0; j < NUM_PUMPS; j++) begin
            active_cnt = active_cnt + 3'(pump_q[j]);
        end
    end

    // Count comes from the registered enables, so a slot freed this cycle is reusable next cycle.
    always_comb begin
        found = 1'b0;
        sel   = 0;
        idx   = 0;
        grant = '0;
        if (!bus.abort && (32'(active_cnt) < MAX_ACTIVE)) begin
            for (int unsigned k = 0; k < NUM_PUMPS; k++) begin
                idx = (32'(rr_ptr) + k) % NUM_PUMPS;
                if (!found && pend[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
        for (int unsigned j = 0; j < NUM_PUMPS; j++) begin
            grant[j] = found && (sel == j);
        end
        rr_next = PTR_W'((sel + 1) % NUM_PUMPS);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= rr_next;
        end
    end

    assign bus.pump       = pump_q;
    assign bus.done       = done_q;
    assign bus.active_cnt = active_cnt;
    assign bus.busy       = |slot_busy;

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed, table-driven checks of pump_scheduler plus multi-cycle corner sequences.
module tb_pump_scheduler;

    logic clk;
    logic RESET;

    pump_scheduler_if #(.NUM_PUMPS(4)) bus0 ();
    pump_scheduler_if #(.NUM_PUMPS(4)) bus1 ();

    pump_scheduler #(
        .NUM_PUMPS  (4),
        .MAX_ACTIVE (2),
        .DOSE_TICKS (3),
        .TICK_W     (4)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus0)
    );

    // Single-slot instance so that grant order is observable one pump at a time.
    pump_scheduler #(
        .NUM_PUMPS  (4),
        .MAX_ACTIVE (1),
        .DOSE_TICKS (2),
        .TICK_W     (4)
    ) dut1 (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       tick;
        logic       abort;
        logic [3:0] pump;
        logic [3:0] done;
        logic [2:0] act;
        logic       busy;
        logic [1:0] rr;
    } vec_t;

    vec_t        tbl[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic [3:0] req, input logic tick,
                                input logic abort, input logic [3:0] pump, input logic [3:0] done,
                                input logic [2:0] act, input logic busy, input logic [1:0] rr);
        vec_t v;
        v.rst = rst; v.req = req; v.tick = tick; v.abort = abort;
        v.pump = pump; v.done = done; v.act = act; v.busy = busy; v.rr = rr;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned order [4];
        int unsigned e;
        int unsigned c;

        order = '{2, 3, 0, 1};
        RESET = 1'b1;
        bus0.req = '0; bus0.tick = 1'b0; bus0.abort = 1'b0;
        bus1.req = '0; bus1.tick = 1'b0; bus1.abort = 1'b0;
        step();

        //    rst  req      tick  abort pump     done     act   busy  rr
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd0);
        // single request, three counted ticks
        add(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd1, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 3'd1, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 3'd1, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd0, 1'b0, 2'd1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd1);
        // concurrency limit: three requests, two slots
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd0);
        add(1'b0, 4'b0111, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 3'd1, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0011, 4'b0000, 3'd2, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0011, 4'b0000, 3'd2, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 4'b0001, 3'd1, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110, 4'b0000, 3'd2, 1'b1, 2'd3);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0010, 3'd1, 1'b1, 2'd3);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 3'd1, 1'b1, 2'd3);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100, 3'd0, 1'b0, 2'd3);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd3);
        // repeated request while pending, running and on the final tick
        add(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 2'd3);
        add(1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 3'd1, 1'b1, 2'd2);
        add(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 3'd1, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 4'b0000, 3'd1, 1'b1, 2'd2);
        add(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0010, 3'd0, 1'b0, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd2);
        // abort with two running, one pending and a fresh request
        add(1'b0, 4'b1011, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b0000, 3'd1, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1001, 4'b0000, 3'd2, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1001, 4'b0000, 3'd2, 1'b1, 2'd1);
        add(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd1);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 1'b0, 2'd1);

        foreach (tbl[i]) begin
            RESET      = tbl[i].rst;
            bus0.req   = tbl[i].req;
            bus0.tick  = tbl[i].tick;
            bus0.abort = tbl[i].abort;
            step();
            check($sformatf("row%0d pump", i), 32'(bus0.pump), 32'(tbl[i].pump));
            check($sformatf("row%0d done", i), 32'(bus0.done), 32'(tbl[i].done));
            check($sformatf("row%0d active_cnt", i), 32'(bus0.active_cnt), 32'(tbl[i].act));
            check($sformatf("row%0d busy", i), 32'(bus0.busy), 32'(tbl[i].busy));
            check($sformatf("row%0d rr_ptr", i), 32'(dut.rr_ptr), 32'(tbl[i].rr));
        end
        RESET = 1'b0; bus0.req = '0; bus0.tick = 1'b0; bus0.abort = 1'b0;

        // round-robin order from rr_ptr=2 with all four pending, one slot
        bus1.req = 4'b0010; step();
        bus1.req = 4'b0000; step();
        check("rr_setup pump", 32'(bus1.pump), 32'h2);
        check("rr_setup rr_ptr", 32'(dut1.rr_ptr), 32'd2);
        bus1.tick = 1'b1; step(); step(); bus1.tick = 1'b0;
        check("rr_setup done", 32'(bus1.done), 32'h2);
        bus1.req = 4'b1111; step();
        bus1.req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            e = order[k];
            for (int w = 0; w < 4 && bus1.pump == 4'b0000; w++) step();
            check($sformatf("rr_grant%0d pump", k), 32'(bus1.pump), 32'd1 << e);
            check($sformatf("rr_grant%0d active_cnt", k), 32'(bus1.active_cnt), 32'd1);
            bus1.tick = 1'b1; step(); step(); bus1.tick = 1'b0;
            check($sformatf("rr_grant%0d done", k), 32'(bus1.done), 32'd1 << e);
            check($sformatf("rr_grant%0d pump_off", k), 32'(bus1.pump), 32'd0);
        end
        step();
        check("rr_end busy", 32'(bus1.busy), 32'd0);

        // reset mid-dose with abort and req asserted
        bus0.req = 4'b0001; step();
        bus0.req = 4'b0000; step();
        check("rst_pre pump", 32'(bus0.pump), 32'h1);
        bus0.tick = 1'b1; step();
        RESET = 1'b1; bus0.abort = 1'b1; bus0.req = 4'b1111; bus0.tick = 1'b1;
        step();
        check("rst pump", 32'(bus0.pump), 32'd0);
        check("rst done", 32'(bus0.done), 32'd0);
        check("rst active_cnt", 32'(bus0.active_cnt), 32'd0);
        check("rst busy", 32'(bus0.busy), 32'd0);
        check("rst rr_ptr", 32'(dut.rr_ptr), 32'd0);
        RESET = 1'b0; bus0.abort = 1'b0; bus0.req = '0; bus0.tick = 1'b0;
        step();
        check("rst_post busy", 32'(bus0.busy), 32'd0);

        // req in cycle 5, tick every 10 cycles: pump high cycles 7..29, done in cycle 30
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus0.req  = (cyc == 5) ? 4'b0001 : 4'b0000;
            bus0.tick = (cyc % 10 == 9);
            step();
            c = 32'(cyc + 1);
            check($sformatf("dose c%0d pump", c), 32'(bus0.pump),
                  (c >= 7 && c <= 29) ? 32'h1 : 32'h0);
            check($sformatf("dose c%0d done", c), 32'(bus0.done),
                  (c == 30) ? 32'h1 : 32'h0);
        end
        bus0.req = '0; bus0.tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
